// File: rtl/logic_hamr_pkg.sv
// rtl/logic_hamr_pkg.sv - shared state encoding and constants for the Logic Hamr command path
package logic_hamr_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ARMED,
    ST_REGEN,
    ST_READ
  } state_t;

  localparam int          BYTES_PER_CH_DEF = 38;
  localparam logic [23:0] DISP_BASE_DEF    = 24'h0;
  localparam logic [7:0]  RD_TIMEOUT_CODE  = 8'hFF;

endpackage

// File: rtl/logic_cmd_sequencer.sv
// rtl/logic_cmd_sequencer.sv - serialises register commands onto the SDRAM read port, capture and regen engines
module logic_cmd_sequencer
  import logic_hamr_pkg::*;
#(
  parameter int                ADDR_W       = 24,
  parameter logic [ADDR_W-1:0] DISP_BASE    = ADDR_W'(DISP_BASE_DEF),
  parameter int                BYTES_PER_CH = BYTES_PER_CH_DEF,
  parameter int                TIMEOUT_CYC  = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_done,
  input  logic              cmd_read,
  input  logic              cmd_regen,
  input  logic              cmd_arm,
  input  logic              cmd_reset,
  input  logic [2:0]        reg_channel,
  input  logic [5:0]        reg_addr,
  output logic              cap_arm,
  output logic              cap_abort,
  input  logic              cap_done,
  output logic              regen_start,
  output logic              regen_abort,
  input  logic              regen_ack,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic [7:0]        rd_data,
  output logic              busy,
  output logic              armed,
  output logic              captured,
  output logic              regen_done,
  output logic [7:0]        read_data,
  output logic              rd_timeout
);

  localparam int              WD_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [5:0]      LAST_IDX = 6'(BYTES_PER_CH - 1);

  state_t            state;
  logic              pend_regen, pend_read, pend_arm;
  logic [WD_W-1:0]   wd;
  logic              launch_regen, launch_read, launch_arm, flush;
  logic [5:0]        byte_idx;
  logic [ADDR_W-1:0] addr_calc;

  always_comb begin
    launch_regen = (state == ST_IDLE) && pend_regen;
    launch_read  = (state == ST_IDLE) && !pend_regen && pend_read;
    launch_arm   = (state == ST_IDLE) && !pend_regen && !pend_read && pend_arm;
    // soft reset and loss of SDRAM init share one clearing path
    flush        = cmd_reset || (!init_done && (state != ST_INIT));
    byte_idx     = (reg_addr > LAST_IDX) ? LAST_IDX : reg_addr;
    addr_calc    = DISP_BASE + ADDR_W'(reg_channel) * ADDR_W'(BYTES_PER_CH) + ADDR_W'(byte_idx);
  end

  assign busy  = (state == ST_REGEN) || (state == ST_READ) || pend_regen || pend_read || pend_arm;
  assign armed = (state == ST_ARMED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_INIT;
      pend_regen  <= 1'b0;
      pend_read   <= 1'b0;
      pend_arm    <= 1'b0;
      wd          <= '0;
      cap_arm     <= 1'b0;
      cap_abort   <= 1'b0;
      regen_start <= 1'b0;
      regen_abort <= 1'b0;
      rd_req      <= 1'b0;
      rd_addr     <= '0;
      captured    <= 1'b0;
      regen_done  <= 1'b0;
      read_data   <= 8'h00;
      rd_timeout  <= 1'b0;
    end else begin
      cap_arm     <= 1'b0;
      cap_abort   <= 1'b0;
      regen_start <= 1'b0;
      regen_abort <= 1'b0;
      if (flush) begin
        cap_abort   <= (state == ST_ARMED);
        regen_abort <= (state == ST_REGEN);
        pend_regen  <= 1'b0;
        pend_read   <= 1'b0;
        pend_arm    <= 1'b0;
        wd          <= '0;
        rd_req      <= 1'b0;
        captured    <= 1'b0;
        regen_done  <= 1'b0;
        read_data   <= 8'h00;
        rd_timeout  <= 1'b0;
        state       <= init_done ? ST_IDLE : ST_INIT;
      end else begin
        // a pulse landing in its own launch cycle re-arms the pending bit
        pend_regen <= (pend_regen & ~launch_regen) | cmd_regen;
        pend_read  <= (pend_read & ~launch_read) | cmd_read;
        pend_arm   <= (pend_arm & ~launch_arm) | (cmd_arm & (state != ST_ARMED));
        case (state)
          ST_INIT: begin
            if (init_done) state <= ST_IDLE;
          end
          ST_IDLE: begin
            if (launch_regen) begin
              regen_start <= 1'b1;
              regen_done  <= 1'b0;
              state       <= ST_REGEN;
            end else if (launch_read) begin
              rd_addr <= addr_calc;
              rd_req  <= 1'b1;
              wd      <= '0;
              state   <= ST_READ;
            end else if (launch_arm) begin
              cap_arm  <= 1'b1;
              captured <= 1'b0;
              state    <= ST_ARMED;
            end
          end
          ST_ARMED: begin
            if (cap_done) begin
              captured <= 1'b1;
              state    <= ST_IDLE;
            end
          end
          ST_REGEN: begin
            if (regen_ack) begin
              regen_done <= 1'b1;
              state      <= ST_IDLE;
            end
          end
          ST_READ: begin
            if (rd_ack) begin
              read_data <= rd_data;
              rd_req    <= 1'b0;
              state     <= ST_IDLE;
            end else if (wd == WD_LAST) begin
              read_data  <= RD_TIMEOUT_CODE;
              rd_timeout <= 1'b1;
              rd_req     <= 1'b0;
              state      <= ST_IDLE;
            end else begin
              wd <= wd + 1'b1;
            end
          end
          default: state <= ST_INIT;
        endcase
      end
    end
  end

endmodule
